nx_boot_loader: RTL and testbench
=================================

# nx_boot_loader

Boot-time sequencer for the nx-riscv core's initialisation ports. It accepts a stream of 32-bit command/payload words over a valid/ready handshake and drives the instruction-RAM, data-RAM and regfile initialisation write ports. It holds the core in reset until an explicit RUN command arrives. It sits between the test/debug host and `nx_riscv_top`: its outputs connect one-to-one to the top's `inst_ram_*`, `data_ram_*_initial` and `regfile_*_initial` inputs, and `core_rst_n` drives the top's `rst_n`.

## Interface
- `INST_DEPTH`, 65536: instruction RAM depth in 32-bit words; used for range checks.
- `DATA_DEPTH`, 1024: data RAM depth in 32-bit words; used for range checks.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: host word valid.
- `in_ready` output 1: loader accepts a word; transfer occurs when `in_valid & in_ready` at a rising edge.
- `in_data` input 32: host word (header, base or payload).
- `load_req` input 1: single-cycle pulse that restarts loading from RUN or ERR.
- `inst_ram_wen` output 1: instruction RAM write strobe.
- `inst_ram_waddr` output 32: instruction RAM byte address.
- `inst_ram_wdata` output 32: instruction RAM write data.
- `data_ram_wen_initial` output 1: data RAM write strobe.
- `data_ram_waddr_initial` output 32: data RAM byte address.
- `data_ram_wdata_initial` output 32: data RAM write data.
- `regfile_wen_initial` output 1: regfile write strobe.
- `regfile_waddr_initial` output 5: register index.
- `regfile_wdata_initial` output 32: register write data.
- `core_rst_n` output 1: core reset, low = core held in reset.
- `busy` output 1: high in S_HDR, S_BASE and S_PAY.
- `err` output 1: high in S_ERR.

## Operation
- **Command format:** header word, then base word, then `count` payload words.
  - Header `[31:30]` is the target: 00 inst, 01 data, 10 reg, 11 RUN.
  - Header `[15:0]` is `count`. Header `[29:16]` is ignored.
  - A RUN header has no base word and no payload.
- **FSM states:** S_HDR, S_BASE, S_PAY, S_RUN, S_ERR. Reset state is S_HDR.
- `in_ready` is 1 in S_HDR, S_BASE and S_PAY; it is 0 in S_RUN and S_ERR.
- **S_HDR:**
  - Accepting a target-11 header goes to S_RUN.
  - Accepting any other header latches target and count, then goes to S_BASE.
- **S_BASE:** accepting the base word runs the range check (below).
  - Check fails: go to S_ERR, no write issued.
  - Check passes and `count`==0: go to S_HDR.
  - Check passes otherwise: latch base into the address register and the 16-bit remaining counter, then go to S_PAY.
- **Range check:** computed in 33-bit arithmetic, so no wrap-around.
  - Inst: `base[1:0]`==0 and `base[31:2]+count <= INST_DEPTH`.
  - Data: `base[1:0]`==0 and `base[31:2]+count <= DATA_DEPTH`.
  - Reg: `base[31:5]`==0 and `base[4:0]+count <= 32`.
- **S_PAY:** each accepted word issues one write to the latched target at the current address.
  - Address advances by +4 for inst/data and by +1 for reg.
  - The remaining counter decrements by 1.
  - Accepting the last word (remaining==1) returns to S_HDR.
  - Writes to x0 are issued; the regfile ignores them.
- **S_RUN:** `core_rst_n`=1. A `load_req` pulse returns to S_HDR and drives `core_rst_n` low.
- **S_ERR:** `err`=1 and `core_rst_n`=0. A `load_req` pulse returns to S_HDR and clears `err`.
- `load_req` is ignored in S_HDR, S_BASE and S_PAY.
- Only one write strobe is ever high in a given cycle.
- Write data and addresses hold their last values when no strobe is active.

## Timing
- **Reset values** (`rst_n` low, asynchronous):
  - State is S_HDR.
  - All `*wen*` outputs, `err` and `core_rst_n` are 0.
  - All address and data outputs are 0.
  - `busy` is 1 and `in_ready` is 1.
- **Write outputs:** all are registered. A payload accepted at edge k gives strobe, address and data valid from edge k to edge k+1, so the RAM or regfile captures the write at edge k+1.
- **Payload throughput:** one word per cycle with no bubbles. `in_valid` low stalls the loader with no timeout.
- **Release:** `core_rst_n` rises at the edge that accepts the RUN header. An immediately preceding final write lands at that same edge, while the core is still in reset.
- **`load_req`:** sampled at edge k in S_RUN or S_ERR; `core_rst_n` falls and `err` clears at edge k.
- **Reset mid-payload:** `rst_n` asserted during S_PAY aborts the transfer immediately. No further writes are issued; words already written stay written.

## Test plan
- **Inst load:** header 0x0000_0003, base 0x0000_0100, payload A, B, C back-to-back.
  - Required: `inst_ram_wen` high for 3 consecutive cycles at 0x100, 0x104, 0x108 with data A, B, C.
  - Then header 0xC000_0000 causes `core_rst_n`=1 and `in_ready`=0.
- **Data load with stalls:** header 0x4000_0002, base 0x0000_0FF8, `in_valid` toggled 1,0,1.
  - Required: writes at 0xFF8 and 0xFFC, one cycle each, separated by exactly one idle cycle.
- **Reg load:** header 0x8000_0002, base 30.
  - Required: writes to index 30 then 31.
  - Base 31 with count 2 instead gives `err`=1, no write, and `in_ready`=0.
- **Range/alignment errors:** data base 0x1000 with count 1 gives `err`. Inst base 0x0000_0002 with count 1 gives `err`.
  - Then a `load_req` pulse clears `err` and `in_ready` returns to 1.
- **Mid-payload reset:** header count 4; assert `rst_n` low after the 2nd payload word.
  - Required: exactly 2 writes seen, all outputs at reset values, and the next word is treated as a header.
- **Restart:** in S_RUN, pulse `load_req`.
  - Required: `core_rst_n`=0 at the next edge, a new count-0 header/base pair is accepted with no writes, then RUN releases `core_rst_n` again.

Source files
------------

// File: rtl/nx_boot_loader.sv
// Boot-time sequencer: turns a host word stream into instruction RAM, data RAM
// and regfile initialisation writes, and holds the core in reset until RUN.
module nx_boot_loader #(
  parameter int unsigned INST_DEPTH = 65536,
  parameter int unsigned DATA_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        load_req,
  output logic        inst_ram_wen,
  output logic [31:0] inst_ram_waddr,
  output logic [31:0] inst_ram_wdata,
  output logic        data_ram_wen_initial,
  output logic [31:0] data_ram_waddr_initial,
  output logic [31:0] data_ram_wdata_initial,
  output logic        regfile_wen_initial,
  output logic [4:0]  regfile_waddr_initial,
  output logic [31:0] regfile_wdata_initial,
  output logic        core_rst_n,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_BASE = 3'd1,
    S_PAY  = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    TGT_INST = 2'b00,
    TGT_DATA = 2'b01,
    TGT_REG  = 2'b10,
    TGT_RUN  = 2'b11
  } target_t;

  localparam logic [32:0] INST_LIMIT = 33'(INST_DEPTH);
  localparam logic [32:0] DATA_LIMIT = 33'(DATA_DEPTH);
  localparam logic [16:0] REG_LIMIT  = 17'd32;

  state_t      state, state_nxt;
  target_t     target;
  logic [15:0] count;
  logic [15:0] remaining;
  logic [31:0] addr;
  logic        accept;
  logic        range_ok;
  logic [32:0] word_end;
  logic [16:0] reg_end;

  assign accept = in_valid & in_ready;

  // End of the requested window, widened so a base near the top of the
  // address space cannot wrap back into range.
  assign word_end = {3'b000, in_data[31:2]} + {17'd0, count};
  assign reg_end  = {12'd0, in_data[4:0]} + {1'b0, count};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement leaves a latch behind.
  always_comb begin
    range_ok = 1'b0;
    case (target)
      TGT_INST: range_ok = (in_data[1:0] == 2'b00) && (word_end <= INST_LIMIT);
      TGT_DATA: range_ok = (in_data[1:0] == 2'b00) && (word_end <= DATA_LIMIT);
      TGT_REG:  range_ok = (in_data[31:5] == 27'd0) && (reg_end <= REG_LIMIT);
      default:  range_ok = 1'b0;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HDR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR: begin
        if (accept) begin
          if (target_t'(in_data[31:30]) == TGT_RUN) state_nxt = S_RUN;
          else                                       state_nxt = S_BASE;
        end
      end
      S_BASE: begin
        if (accept) begin
          if (!range_ok)          state_nxt = S_ERR;
          else if (count == '0)   state_nxt = S_HDR;
          else                    state_nxt = S_PAY;
        end
      end
      S_PAY: begin
        if (accept && (remaining == 16'd1)) state_nxt = S_HDR;
      end
      S_RUN, S_ERR: begin
        if (load_req) state_nxt = S_HDR;
      end
      default: state_nxt = S_HDR;
    endcase
  end

  assign in_ready   = (state == S_HDR) || (state == S_BASE) || (state == S_PAY);
  assign busy       = in_ready;
  assign err        = (state == S_ERR);
  assign core_rst_n = (state == S_RUN);

  // Command registers and the registered write ports. Strobes are single-cycle;
  // address/data hold their last value between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target                 <= TGT_INST;
      count                  <= '0;
      remaining              <= '0;
      addr                   <= '0;
      inst_ram_wen           <= 1'b0;
      inst_ram_waddr         <= '0;
      inst_ram_wdata         <= '0;
      data_ram_wen_initial   <= 1'b0;
      data_ram_waddr_initial <= '0;
      data_ram_wdata_initial <= '0;
      regfile_wen_initial    <= 1'b0;
      regfile_waddr_initial  <= '0;
      regfile_wdata_initial  <= '0;
    end else begin
      inst_ram_wen         <= 1'b0;
      data_ram_wen_initial <= 1'b0;
      regfile_wen_initial  <= 1'b0;

      if ((state == S_HDR) && accept) begin
        target <= target_t'(in_data[31:30]);
        count  <= in_data[15:0];
      end

      if ((state == S_BASE) && accept && range_ok) begin
        addr      <= in_data;
        remaining <= count;
      end

      if ((state == S_PAY) && accept) begin
        remaining <= remaining - 16'd1;
        case (target)
          TGT_INST: begin
            inst_ram_wen   <= 1'b1;
            inst_ram_waddr <= addr;
            inst_ram_wdata <= in_data;
            addr           <= addr + 32'd4;
          end
          TGT_DATA: begin
            data_ram_wen_initial   <= 1'b1;
            data_ram_waddr_initial <= addr;
            data_ram_wdata_initial <= in_data;
            addr                   <= addr + 32'd4;
          end
          TGT_REG: begin
            regfile_wen_initial   <= 1'b1;
            regfile_waddr_initial <= addr[4:0];
            regfile_wdata_initial <= in_data;
            addr                  <= addr + 32'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nx_boot_loader.sv
// Self-checking bench for nx_boot_loader: directed scenarios plus randomized
// commands compared against a write-list model built from the command rules.
module tb_nx_boot_loader;

  localparam int INST_DEPTH = 65536;
  localparam int DATA_DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        load_req = 1'b0;
  logic        inst_ram_wen;
  logic [31:0] inst_ram_waddr, inst_ram_wdata;
  logic        data_ram_wen_initial;
  logic [31:0] data_ram_waddr_initial, data_ram_wdata_initial;
  logic        regfile_wen_initial;
  logic [4:0]  regfile_waddr_initial;
  logic [31:0] regfile_wdata_initial;
  logic        core_rst_n, busy, err;

  nx_boot_loader #(.INST_DEPTH(INST_DEPTH), .DATA_DEPTH(DATA_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .load_req(load_req),
    .inst_ram_wen(inst_ram_wen), .inst_ram_waddr(inst_ram_waddr),
    .inst_ram_wdata(inst_ram_wdata),
    .data_ram_wen_initial(data_ram_wen_initial),
    .data_ram_waddr_initial(data_ram_waddr_initial),
    .data_ram_wdata_initial(data_ram_wdata_initial),
    .regfile_wen_initial(regfile_wen_initial),
    .regfile_waddr_initial(regfile_waddr_initial),
    .regfile_wdata_initial(regfile_wdata_initial),
    .core_rst_n(core_rst_n), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 inst, 1 data, 2 reg
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Collect every write the DUT presents, mid-cycle.
  always @(negedge clk) begin
    if (inst_ram_wen)         obs_q.push_back('{0, inst_ram_waddr, inst_ram_wdata});
    if (data_ram_wen_initial) obs_q.push_back('{1, data_ram_waddr_initial, data_ram_wdata_initial});
    if (regfile_wen_initial)  obs_q.push_back('{2, {27'd0, regfile_waddr_initial}, regfile_wdata_initial});
    if (inst_ram_wen || data_ram_wen_initial || regfile_wen_initial)
      check("one_strobe", {31'd0, inst_ram_wen} + {31'd0, data_ram_wen_initial}
                          + {31'd0, regfile_wen_initial}, 32'd1);
  end

  // Reference: decide legality from plain integer arithmetic, then list the
  // writes the supplied payload words must produce.
  function automatic bit model_cmd(input logic [31:0] hdr, input logic [31:0] base,
                                   input logic [31:0] pay[$]);
    int     kind = int'(hdr[31:30]);
    longint cnt  = longint'({48'd0, hdr[15:0]});
    longint b    = longint'({32'd0, base});
    bit     ok;
    case (kind)
      0:       ok = (b % 4 == 0) && (b / 4 + cnt <= INST_DEPTH);
      1:       ok = (b % 4 == 0) && (b / 4 + cnt <= DATA_DEPTH);
      default: ok = (b < 32) && (b + cnt <= 32);
    endcase
    if (ok) begin
      foreach (pay[i]) begin
        wr_t w;
        w.kind = kind;
        w.data = pay[i];
        w.addr = (kind == 2) ? 32'(b + i) : 32'(b + 4 * i);
        exp_q.push_back(w);
      end
    end
    return ok;
  endfunction

  task automatic send(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    @(negedge clk); #1;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      wr_t e = exp_q.pop_front();
      wr_t o = obs_q.pop_front();
      check({tag, "_kind"}, o.kind, e.kind);
      check({tag, "_addr"}, o.addr, e.addr);
      check({tag, "_data"}, o.data, e.data);
    end
    exp_q.delete();
    obs_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pay[$];
    logic [31:0] hdr, base;
    bit          ok;

    // ---- reset values
    #12;
    check("rst_inst_wen", {31'd0, inst_ram_wen}, 0);
    check("rst_data_wen", {31'd0, data_ram_wen_initial}, 0);
    check("rst_reg_wen", {31'd0, regfile_wen_initial}, 0);
    check("rst_inst_waddr", inst_ram_waddr, 0);
    check("rst_data_wdata", data_ram_wdata_initial, 0);
    check("rst_reg_waddr", {27'd0, regfile_waddr_initial}, 0);
    check("rst_core_rst_n", {31'd0, core_rst_n}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_busy", {31'd0, busy}, 1);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- instruction load, back-to-back payload, then RUN
    pay.delete(); pay.push_back(32'hA0A0_0001); pay.push_back(32'hB0B0_0002); pay.push_back(32'hC0C0_0003);
    void'(model_cmd(32'h0000_0003, 32'h0000_0100, pay));
    send(32'h0000_0003);
    send(32'h0000_0100);
    for (int i = 0; i < 3; i++) begin
      send(pay[i]);
      check("inst_wen", {31'd0, inst_ram_wen}, 1);
      check("inst_waddr", inst_ram_waddr, 32'h100 + 32'(4 * i));
      check("inst_wdata", inst_ram_wdata, pay[i]);
    end
    send(32'hC000_0000);
    check("run_core_rst_n", {31'd0, core_rst_n}, 1);
    check("run_in_ready", {31'd0, in_ready}, 0);
    check("run_busy", {31'd0, busy}, 0);
    check("run_inst_wen_low", {31'd0, inst_ram_wen}, 0);
    check("run_waddr_hold", inst_ram_waddr, 32'h108);
    compare_writes("inst");

    // ---- restart from RUN with an empty command
    pulse_load();
    check("restart_core_rst_n", {31'd0, core_rst_n}, 0);
    check("restart_in_ready", {31'd0, in_ready}, 1);
    send(32'h0000_0000);
    send(32'h0000_0000);
    check("restart_hdr_ready", {31'd0, in_ready}, 1);
    send(32'hC000_0000);
    check("restart_run", {31'd0, core_rst_n}, 1);
    compare_writes("restart");
    pulse_load();

    // ---- data load at the top of data RAM with a one-cycle stall
    pay.delete(); pay.push_back(32'hD000_0000); pay.push_back(32'hD000_0001);
    void'(model_cmd(32'h4000_0002, 32'h0000_0FF8, pay));
    send(32'h4000_0002);
    send(32'h0000_0FF8);
    send(pay[0]);
    check("data_wen0", {31'd0, data_ram_wen_initial}, 1);
    check("data_waddr0", data_ram_waddr_initial, 32'hFF8);
    idle(1);
    check("data_stall_idle", {31'd0, data_ram_wen_initial}, 0);
    send(pay[1]);
    check("data_wen1", {31'd0, data_ram_wen_initial}, 1);
    check("data_waddr1", data_ram_waddr_initial, 32'hFFC);
    check("data_wdata1", data_ram_wdata_initial, 32'hD000_0001);
    compare_writes("data");

    // ---- regfile load ending at x31
    pay.delete(); pay.push_back(32'h1111_0000); pay.push_back(32'h2222_0000);
    void'(model_cmd(32'h8000_0002, 32'd30, pay));
    send(32'h8000_0002);
    send(32'd30);
    send(pay[0]);
    check("reg_waddr0", {27'd0, regfile_waddr_initial}, 30);
    send(pay[1]);
    check("reg_waddr1", {27'd0, regfile_waddr_initial}, 31);
    check("reg_wdata1", regfile_wdata_initial, 32'h2222_0000);
    compare_writes("reg");

    // ---- regfile overrun is rejected
    pay.delete();
    void'(model_cmd(32'h8000_0002, 32'd31, pay));
    send(32'h8000_0002);
    send(32'd31);
    check("reg_oob_err", {31'd0, err}, 1);
    check("reg_oob_ready", {31'd0, in_ready}, 0);
    check("reg_oob_core", {31'd0, core_rst_n}, 0);
    pulse_load();
    check("reg_oob_clear", {31'd0, err}, 0);
    check("reg_oob_ready_back", {31'd0, in_ready}, 1);
    compare_writes("reg_oob");

    // ---- data out of range, then misaligned instruction base
    send(32'h4000_0001);
    send(32'h0000_1000);
    check("data_oob_err", {31'd0, err}, 1);
    pulse_load();
    send(32'h0000_0001);
    send(32'h0000_0002);
    check("inst_misalign_err", {31'd0, err}, 1);
    pulse_load();
    check("misalign_clear", {31'd0, err}, 0);
    check("misalign_ready", {31'd0, in_ready}, 1);
    compare_writes("range_err");

    // ---- reset in the middle of a four-word payload
    pay.delete(); pay.push_back(32'h5EED_0000); pay.push_back(32'h5EED_0001);
    void'(model_cmd(32'h0000_0004, 32'h0000_0200, pay));
    send(32'h0000_0004);
    send(32'h0000_0200);
    send(pay[0]);
    send(pay[1]);
    check("mid_wen", {31'd0, inst_ram_wen}, 1);
    check("mid_waddr", inst_ram_waddr, 32'h204);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wen", {31'd0, inst_ram_wen}, 0);
    check("mid_rst_waddr", inst_ram_waddr, 0);
    check("mid_rst_wdata", inst_ram_wdata, 0);
    check("mid_rst_ready", {31'd0, in_ready}, 1);
    check("mid_rst_core", {31'd0, core_rst_n}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    compare_writes("mid_reset");
    send(32'hC000_0000);
    check("mid_next_is_hdr", {31'd0, core_rst_n}, 1);
    pulse_load();

    // ---- randomized commands against the model
    for (int t = 0; t < 40; t++) begin
      int          kind  = $urandom_range(0, 2);
      int          cnt   = $urandom_range(0, 5);
      int          depth = (kind == 0) ? INST_DEPTH : DATA_DEPTH;
      int          r     = $urandom_range(0, 7);
      logic [1:0]  k2    = 2'(kind);
      if (kind == 2) begin
        base = (r == 0) ? 32'h8000_0001 : 32'($urandom_range(0, 35));
      end else begin
        if (r == 0)      base = 32'hFFFF_FFFC;
        else if (r < 4)  base = 32'($urandom_range(0, 40) * 4);
        else             base = 32'((depth - $urandom_range(0, 6)) * 4);
        if ($urandom_range(0, 5) == 0) base = base | 32'($urandom_range(1, 3));
      end
      hdr = {k2, 14'($urandom), 16'(cnt)};
      pay.delete();
      for (int i = 0; i < cnt; i++) pay.push_back($urandom);
      ok = model_cmd(hdr, base, pay);
      send(hdr);
      idle($urandom_range(0, 2));
      send(base);
      if (ok) begin
        foreach (pay[i]) begin
          idle($urandom_range(0, 1));
          send(pay[i]);
        end
        check("rand_no_err", {31'd0, err}, 0);
      end else begin
        check("rand_err", {31'd0, err}, 1);
        pulse_load();
        check("rand_err_clear", {31'd0, err}, 0);
      end
      compare_writes("rand");
    end

    send(32'hC000_0000);
    check("final_run", {31'd0, core_rst_n}, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
